// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with a one-entry valid/ready output register.
// Define UART_RX_MAJORITY_EN to take each bit decision as a 3-sample majority vote.
module uart_rx_ovs #(
  parameter int DATA_BITS   = 8,
  parameter int OVS_FACTOR  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick_ovs,
  input  logic                 rx_pin,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 rx_busy
);

  localparam int CNT_W = $clog2(OVS_FACTOR);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] C_START  = CNT_W'(OVS_FACTOR / 2 - 1);
  localparam logic [CNT_W-1:0] C_BIT    = CNT_W'(OVS_FACTOR - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP1  = 3'd4;
  localparam logic [2:0] ST_STOP2  = 3'd5;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic                   bit_dec;

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     ovs_cnt_q, ovs_cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           pmode_q, pmode_d;
  logic                 two_stop_q, two_stop_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  logic                 decide;
  logic                 complete;
  logic                 load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_pin};
    end
  end

  assign rxs = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
  // The two most recent tick samples; at the decision tick they hold counts c-2 and c-1.
  logic [1:0] smp_q, smp_d;

  always_comb begin
    smp_d = smp_q;
    if (tick_ovs) begin
      smp_d = {smp_q[0], rxs};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      smp_q <= 2'b11;
    end else begin
      smp_q <= smp_d;
    end
  end

  assign bit_dec = (smp_q[1] & smp_q[0]) | (smp_q[1] & rxs) | (smp_q[0] & rxs);
`else
  assign bit_dec = rxs;
`endif

  assign decide = tick_ovs && (state_q != ST_IDLE) &&
                  (ovs_cnt_q == ((state_q == ST_START) ? C_START : C_BIT));

  always_comb begin
    state_d    = state_q;
    ovs_cnt_d  = tick_ovs ? ovs_cnt_q + CNT_W'(1) : ovs_cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    pmode_d    = pmode_q;
    two_stop_d = two_stop_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    complete   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          state_d    = ST_START;
          pmode_d    = parity_mode;
          two_stop_d = two_stop;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
        end
      end
      ST_START: begin
        if (decide) begin
          if (bit_dec) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            idx_d   = '0;
          end
        end
      end
      ST_DATA: begin
        if (decide) begin
          shift_d = {bit_dec, shift_q[DATA_BITS-1:1]};
          if (idx_q == LAST_IDX) begin
            state_d = (pmode_q[0] ^ pmode_q[1]) ? ST_PARITY : ST_STOP1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        // Odd mode (10) expects the inverse of the data XOR.
        if (decide) begin
          if (bit_dec != ((^shift_q) ^ pmode_q[1])) begin
            perr_d = 1'b1;
          end
          state_d = ST_STOP1;
        end
      end
      ST_STOP1: begin
        if (decide) begin
          if (!bit_dec) begin
            ferr_d = 1'b1;
          end
          if (two_stop_q) begin
            state_d = ST_STOP2;
          end else begin
            state_d  = ST_IDLE;
            complete = 1'b1;
          end
        end
      end
      ST_STOP2: begin
        if (decide) begin
          if (!bit_dec) begin
            ferr_d = 1'b1;
          end
          state_d  = ST_IDLE;
          complete = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d != state_q) begin
      ovs_cnt_d = '0;
    end
  end

  // A completing frame may replace a word that is being handed over in the same cycle.
  assign load = complete && (!rx_valid_q || rx_ready);

  always_comb begin
    rx_data_d    = rx_data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    rx_valid_d   = rx_valid_q;
    overrun_d    = complete && !load;
    if (load) begin
      rx_data_d    = shift_q;
      parity_err_d = perr_q;
      frame_err_d  = ferr_d;
      rx_valid_d   = 1'b1;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ovs_cnt_q    <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      pmode_q      <= 2'b00;
      two_stop_q   <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ovs_cnt_q    <= ovs_cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      pmode_q      <= pmode_d;
      two_stop_q   <= two_stop_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;
  assign rx_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Bench for uart_rx_ovs: table-driven frames, randomized frames against a frame-level
// model, and hand-written sequences for glitches, overrun, majority voting and reset.
module tb_uart_rx_ovs;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_ovs;
  logic       rx_pin;
  logic [1:0] parity_mode;
  logic       two_stop;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;
  logic       rx_busy;

  logic [1:0] tick_cnt = 2'd0;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } rx_t;

  rx_t mon_q[$];
  int  rd_idx = 0;
  int  valid_cycles = 0;
  int  ovr_cnt = 0;

  typedef struct {
    logic [7:0] data;
    logic [1:0] pm;
    logic       ts;
    logic       pbit;
    logic       s1;
    logic       s2;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[7];

  uart_rx_ovs #(
    .DATA_BITS  (8),
    .OVS_FACTOR (16),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick_ovs   (tick_ovs),
    .rx_pin     (rx_pin),
    .parity_mode(parity_mode),
    .two_stop   (two_stop),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun_err(overrun_err),
    .rx_busy    (rx_busy)
  );

  always #5 clk = ~clk;

  // Oversample tick every 4 clocks.
  always @(posedge clk) tick_cnt <= tick_cnt + 2'd1;
  assign tick_ovs = (tick_cnt == 2'd3);

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) valid_cycles++;
      if (overrun_err) ovr_cnt++;
      if (rx_valid && rx_ready) begin
        mon_q.push_back('{rx_data, parity_err, frame_err});
        $display("transfer: data=%02h parity_err=%0d frame_err=%0d", rx_data, parity_err, frame_err);
      end
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx_pin = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start each frame just after the edge where tick_cnt becomes 1 so bit centres are known.
  task automatic align();
    do begin
      @(posedge clk);
      #1;
    end while (tick_cnt != 2'd1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic ts,
                            input logic pbit, input logic s1, input logic s2, input int glitch);
    logic last;
    align();
    parity_mode = pm;
    two_stop    = ts;
    drive_bit(1'b0, 64);
    // Scramble the config inputs mid-frame; the receiver must use the latched values.
    parity_mode = 2'($urandom_range(0, 3));
    two_stop    = 1'($urandom_range(0, 1));
    for (int i = 0; i < 8; i++) begin
      if (i == glitch) begin
        drive_bit(d[i], 32);
        drive_bit(1'b0, 4);
        drive_bit(d[i], 28);
      end else begin
        drive_bit(d[i], 64);
      end
    end
    if (pm == 2'b01 || pm == 2'b10) drive_bit(pbit, 64);
    if (ts) begin
      drive_bit(s1, 64);
      last = s2;
    end else begin
      last = s1;
    end
    if (!last) begin
      drive_bit(1'b0, 48);
      drive_bit(1'b1, 16);
    end else begin
      drive_bit(1'b1, 64);
    end
    drive_bit(1'b1, 128);
  endtask

  // Frame-level reference: what a receiver must report for the bits placed on the line.
  function automatic void model(input logic [7:0] d, input logic [1:0] pm, input logic ts,
                                input logic pbit, input logic s1, input logic s2,
                                output logic [7:0] ed, output logic ep, output logic ef);
    int ones;
    ones = $countones(d) + int'(pbit);
    ed = d;
    if (pm == 2'b01)      ep = (ones % 2) != 0;
    else if (pm == 2'b10) ep = (ones % 2) != 1;
    else                  ep = 1'b0;
    ef = !s1 || (ts && !s2);
  endfunction

  task automatic check_frame(input string name, input logic [7:0] ed, input logic ep,
                             input logic ef, input int v0);
    check({name, ".count"}, 32'(mon_q.size() - rd_idx), 32'd1);
    if (mon_q.size() > rd_idx) begin
      check({name, ".rx_data"}, 32'(mon_q[rd_idx].data), 32'(ed));
      check({name, ".parity_err"}, 32'(mon_q[rd_idx].perr), 32'(ep));
      check({name, ".frame_err"}, 32'(mon_q[rd_idx].ferr), 32'(ef));
    end
    rd_idx = mon_q.size();
    check({name, ".valid_cycles"}, 32'(valid_cycles - v0), 32'd1);
    check({name, ".rx_busy"}, 32'(rx_busy), 32'd0);
  endtask

  initial begin
    logic [7:0] d, ed;
    logic [1:0] pm;
    logic       ts, pb, s1, s2, ep, ef;
    int         v0, o0;

    vecs[0] = '{8'hA5, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h37, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h37, 1'b1, 1'b0};
    vecs[2] = '{8'h37, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 8'h37, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[5] = '{8'hC6, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 8'hC6, 1'b0, 1'b0};
    vecs[6] = '{8'h5A, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b1};

    reset       = 1'b1;
    rx_pin      = 1'b1;
    rx_ready    = 1'b1;
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    repeat (5) @(negedge clk);
    check("reset.rx_data", 32'(rx_data), 32'd0);
    check("reset.rx_valid", 32'(rx_valid), 32'd0);
    check("reset.parity_err", 32'(parity_err), 32'd0);
    check("reset.frame_err", 32'(frame_err), 32'd0);
    check("reset.overrun_err", 32'(overrun_err), 32'd0);
    check("reset.rx_busy", 32'(rx_busy), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive_bit(1'b1, 64);

    for (int i = 0; i < 7; i++) begin
      v0 = valid_cycles;
      send_frame(vecs[i].data, vecs[i].pm, vecs[i].ts, vecs[i].pbit, vecs[i].s1, vecs[i].s2, -1);
      check_frame($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr, v0);
    end

    for (int i = 0; i < 16; i++) begin
      d  = 8'($urandom_range(0, 255));
      pm = 2'($urandom_range(0, 3));
      ts = 1'($urandom_range(0, 1));
      pb = 1'($urandom_range(0, 1));
      s1 = ($urandom_range(0, 3) != 0);
      s2 = ($urandom_range(0, 3) != 0);
      model(d, pm, ts, pb, s1, s2, ed, ep, ef);
      v0 = valid_cycles;
      send_frame(d, pm, ts, pb, s1, s2, -1);
      check_frame($sformatf("rand%0d", i), ed, ep, ef, v0);
    end

    // Short low glitch: false start, no delivery.
    v0 = valid_cycles;
    align();
    drive_bit(1'b0, 16);
    check("glitch.busy_during", 32'(rx_busy), 32'd1);
    drive_bit(1'b1, 128);
    check("glitch.busy_after", 32'(rx_busy), 32'd0);
    check("glitch.count", 32'(mon_q.size() - rd_idx), 32'd0);
    check("glitch.valid_cycles", 32'(valid_cycles - v0), 32'd0);

    // Overrun: second frame is dropped while the first is held.
    rx_ready = 1'b0;
    o0 = ovr_cnt;
    send_frame(8'h11, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    send_frame(8'h22, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    check("overrun.pulses", 32'(ovr_cnt - o0), 32'd1);
    check("overrun.rx_valid_held", 32'(rx_valid), 32'd1);
    check("overrun.rx_data_held", 32'(rx_data), 32'h11);
    check("overrun.no_transfer", 32'(mon_q.size() - rd_idx), 32'd0);
    rx_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("overrun.drain_count", 32'(mon_q.size() - rd_idx), 32'd1);
    if (mon_q.size() > rd_idx) check("overrun.drain_data", 32'(mon_q[rd_idx].data), 32'h11);
    rd_idx = mon_q.size();
    check("overrun.rx_valid_after", 32'(rx_valid), 32'd0);

    // One-tick glitch at the centre of data bit 3.
    v0 = valid_cycles;
    send_frame(8'hFF, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3);
`ifdef UART_RX_MAJORITY_EN
    check_frame("centre_glitch", 8'hFF, 1'b0, 1'b0, v0);
`else
    check_frame("centre_glitch", 8'hF7, 1'b0, 1'b0, v0);
`endif

    // Reset mid-frame while a word is held.
    rx_ready = 1'b0;
    send_frame(8'h5A, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    check("midreset.held_before", 32'(rx_valid), 32'd1);
    align();
    drive_bit(1'b0, 64);
    drive_bit(1'b1, 100);
    reset = 1'b1;
    drive_bit(1'b1, 3);
    @(negedge clk);
    check("midreset.rx_data", 32'(rx_data), 32'd0);
    check("midreset.rx_valid", 32'(rx_valid), 32'd0);
    check("midreset.parity_err", 32'(parity_err), 32'd0);
    check("midreset.frame_err", 32'(frame_err), 32'd0);
    check("midreset.overrun_err", 32'(overrun_err), 32'd0);
    check("midreset.rx_busy", 32'(rx_busy), 32'd0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    rx_ready = 1'b1;
    drive_bit(1'b1, 256);
    check("midreset.nothing_delivered", 32'(mon_q.size() - rd_idx), 32'd0);
    v0 = valid_cycles;
    send_frame(8'hC3, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    check_frame("after_reset", 8'hC3, 1'b0, 1'b0, v0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
